bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
- Parametrised BCD minutes:seconds countdown timer for the microwave controller; successor to the fixed 1-digit-minute timer.
- Keypad digits shift in from the right; start/pause/cancel control; on-chip prescaler generates the 1 s decrement tick.
- Drives the 7-seg display digits and flags completion to the cook-control FSM.

Parameters:
- MIN_DIGITS, 1, number of BCD minute digits (1..4).
- TICK_DIV, 1, clk cycles per one-second decrement (>=1); 1 = decrement every clk.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit is a keypad entry.
- key_digit  in  4  BCD digit; values >9 ignored.
- start  in  1  begin/resume countdown.
- pause  in  1  suspend countdown (door open / pause key).
- cancel  in  1  abort and clear all digits.
- add30  in  1  add 30 s (effective only with TIMER_ADD30_EN).
- sec_ones  out  4  seconds units digit.
- sec_tens  out  4  seconds tens digit.
- mins  out  4*MIN_DIGITS  minute digits, digit 0 in bits [3:0].
- running  out  1  high in RUN.
- zero  out  1  all digits == 0 (combinational from registers).
- tc  out  1  one-cycle pulse on reaching 0:00 in RUN.

Behaviour:
- One clock; reset is synchronous, active-high on clr. Reset: all digits 0, state IDLE, prescaler 0, running=0, tc=0, zero=1.
- Priority each cycle: clr > cancel > pause > start > add30 > key_valid.
- States: IDLE (accept keys), RUN, PAUSE, DONE.
- IDLE: key_valid with key_digit<=9 shifts left: mins[top] dropped, mins up one digit, sec_tens->mins[3:0], sec_ones->sec_tens, key_digit->sec_ones; visible next cycle. start with zero=0 -> RUN, prescaler cleared; start with zero=1 ignored.
- RUN: prescaler counts 0..TICK_DIV-1; on wrap, decrement time by 1 s. key_valid ignored. pause -> PAUSE (prescaler held). Decrement rule: sec_ones 0->9 borrow; sec_tens 0->5 borrow; mins BCD-decrement with borrow between digits. sec_tens entered >5 (e.g. 1:90) counts down as entered: 1:90, 1:89 .. 1:00, 0:59.
- Decrement producing 0:00: same edge asserts tc for exactly one cycle, state -> DONE, running=0.
- PAUSE: counting frozen, keys ignored; start -> RUN with prescaler resumed from held value.
- DONE: digits 0:00; key_valid shifts in and returns to IDLE; start ignored.
- cancel (any state): digits cleared, state IDLE, no tc.
- start and pause same cycle: pause wins.
- tc never asserted by cancel, clr, or entry into IDLE.

Optional Feature:
- Macro TIMER_ADD30_EN.
- Defined: add30 pulse adds 30 s in BCD (sec_tens+3; >5 wraps -6 and carries to mins). Saturates at all-9 minutes and 59 s. In IDLE/DONE also enters RUN (quick start). In RUN/PAUSE adds without a state change.
- Undefined: add30 ignored, no adder logic generated.

Test Plan:
- MIN_DIGITS=2, TICK_DIV=1: keys 1,3,0 -> mins=01, sec_tens=3, sec_ones=0; start -> 1:29 next cycle; tc pulses once on the 90th decrement cycle; zero=1; state DONE.
- TICK_DIV=4: load 0:02, start -> decrements exactly every 4 clk; tc after 8 clk; running falls the same edge.
- Pause mid-count at 0:45 for 10 clk -> digits hold; start -> resumes, next decrement after the remaining prescaler count only.
- Borrow chain: MIN_DIGITS=2 load 10:00 -> 09:59; entered 1:90 -> 1:89; key 0xA ignored; 5 keys with MIN_DIGITS=1 drops the oldest digit.
- Simultaneous start+pause in IDLE with 0:05 -> stays IDLE; cancel in RUN -> all 0, tc=0; clr mid-RUN -> reset values next cycle.
- TIMER_ADD30_EN, MIN_DIGITS=1: add30 in IDLE -> 0:30 RUN; add30 at 9:45 -> 9:59 saturated; add30 at 0:40 -> 1:10.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// BCD minutes:seconds countdown timer with keypad entry, start/pause/cancel and on-chip 1 s prescaler.
// Latency: key entry and control take effect on the next clk edge; tc is a registered one-cycle pulse.
// Backpressure: none; strobes are sampled every cycle with priority clr > cancel > pause > start > add30 > key_valid.
//
// Optional feature macro: TIMER_ADD30_EN (add30 adds 30 s, saturating; quick-starts from IDLE/DONE).
//
// Ports:
//   clk_i          rising-edge clock
//   clr_i          synchronous active-high reset
//   key_valid_i    one-cycle keypad strobe, key_digit_i is the entered BCD digit (>9 ignored)
//   start_i        begin / resume countdown
//   pause_i        suspend countdown
//   cancel_i       abort and clear all digits
//   add30_i        add 30 s (only with TIMER_ADD30_EN)
//   sec_ones_o     seconds units digit
//   sec_tens_o     seconds tens digit
//   mins_o         minute digits, digit 0 in [3:0]
//   running_o      high while counting
//   zero_o         all digits are zero
//   tc_o           one-cycle pulse when a decrement reaches 0:00
module bcd_countdown_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    key_valid_i,
    input  logic [3:0]              key_digit_i,
    input  logic                    start_i,
    input  logic                    pause_i,
    input  logic                    cancel_i,
    input  logic                    add30_i,
    output logic [3:0]              sec_ones_o,
    output logic [3:0]              sec_tens_o,
    output logic [4*MIN_DIGITS-1:0] mins_o,
    output logic                    running_o,
    output logic                    zero_o,
    output logic                    tc_o
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [3:0]      sec_ones_q, sec_ones_d;
    logic [3:0]      sec_tens_q, sec_tens_d;
    logic [MW-1:0]   mins_q, mins_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic            tc_q, tc_d;

    logic            tick;
    logic            key_ok;
    logic [3:0]      dec_ones, dec_tens;
    logic [MW-1:0]   dec_mins;
    logic            dec_borrow;
    logic            dec_zero;

    assign tick   = (presc_q == PRESC_MAX);
    assign key_ok = key_valid_i && (key_digit_i <= 4'd9);

    // One-second BCD decrement. A seconds-tens digit entered above 5 simply
    // counts down from where it is; only a borrow out of zero reloads 5.
    always_comb begin
        dec_borrow = 1'b0;
        if (sec_ones_q == 4'd0) begin
            dec_ones   = 4'd9;
            dec_borrow = 1'b1;
        end else begin
            dec_ones = sec_ones_q - 4'd1;
        end
        dec_tens = sec_tens_q;
        if (dec_borrow) begin
            if (sec_tens_q == 4'd0) begin
                dec_tens = 4'd5;
            end else begin
                dec_tens   = sec_tens_q - 4'd1;
                dec_borrow = 1'b0;
            end
        end
        dec_mins = mins_q;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (dec_borrow) begin
                if (mins_q[4*i +: 4] == 4'd0) begin
                    dec_mins[4*i +: 4] = 4'd9;
                end else begin
                    dec_mins[4*i +: 4] = mins_q[4*i +: 4] - 4'd1;
                    dec_borrow         = 1'b0;
                end
            end
        end
        dec_zero = (dec_mins == '0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    end

`ifdef TIMER_ADD30_EN
    logic [3:0]    base_ones, base_tens;
    logic [MW-1:0] base_mins;
    logic [3:0]    add_ones, add_tens;
    logic [MW-1:0] add_mins;
    logic [4:0]    add_tens_sum;
    logic [4:0]    add_tens_wrap;
    logic          add_carry;

    // In RUN the add is applied on top of this edge's decrement so no second is lost.
    always_comb begin
        if ((state_q == ST_RUN) && tick) begin
            base_ones = dec_ones;
            base_tens = dec_tens;
            base_mins = dec_mins;
        end else begin
            base_ones = sec_ones_q;
            base_tens = sec_tens_q;
            base_mins = mins_q;
        end
    end

    always_comb begin
        add_carry     = 1'b0;
        add_ones      = base_ones;
        add_tens_sum  = {1'b0, base_tens} + 5'd3;
        add_tens_wrap = add_tens_sum - 5'd6;
        add_tens      = add_tens_sum[3:0];
        if (add_tens_sum > 5'd5) begin
            add_tens  = add_tens_wrap[3:0];
            add_carry = 1'b1;
        end
        add_mins = base_mins;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (add_carry) begin
                if (base_mins[4*i +: 4] >= 4'd9) begin
                    add_mins[4*i +: 4] = 4'd0;
                end else begin
                    add_mins[4*i +: 4] = base_mins[4*i +: 4] + 4'd1;
                    add_carry          = 1'b0;
                end
            end
        end
        // Carry out of the top minute digit: clamp to the largest displayable time.
        if (add_carry) begin
            for (int i = 0; i < MIN_DIGITS; i++) begin
                add_mins[4*i +: 4] = 4'd9;
            end
            add_tens = 4'd5;
            add_ones = 4'd9;
        end
    end
`else
    logic unused_add30;
    assign unused_add30 = add30_i;
`endif

    always_comb begin
        state_d    = state_q;
        sec_ones_d = sec_ones_q;
        sec_tens_d = sec_tens_q;
        mins_d     = mins_q;
        presc_d    = presc_q;
        tc_d       = 1'b0;

        if (cancel_i) begin
            state_d    = ST_IDLE;
            sec_ones_d = 4'd0;
            sec_tens_d = 4'd0;
            mins_d     = '0;
            presc_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    // start is swallowed here in DONE (display is 0:00 anyway) and
                    // when the display is zero in IDLE; pause has no meaning here.
                    if (!pause_i && !start_i) begin
`ifdef TIMER_ADD30_EN
                        if (add30_i) begin
                            state_d    = ST_RUN;
                            presc_d    = '0;
                            sec_ones_d = add_ones;
                            sec_tens_d = add_tens;
                            mins_d     = add_mins;
                        end else
`endif
                        if (key_ok) begin
                            state_d    = ST_IDLE;
                            sec_ones_d = key_digit_i;
                            sec_tens_d = sec_ones_q;
                            mins_d[3:0] = sec_tens_q;
                            for (int i = 1; i < MIN_DIGITS; i++) begin
                                mins_d[4*i +: 4] = mins_q[4*(i-1) +: 4];
                            end
                        end
                    end else if (!pause_i && (state_q == ST_IDLE) && !zero_o) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (pause_i) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = tick ? '0 : presc_q + PW'(1);
`ifdef TIMER_ADD30_EN
                        if (add30_i) begin
                            sec_ones_d = add_ones;
                            sec_tens_d = add_tens;
                            mins_d     = add_mins;
                        end else
`endif
                        if (tick) begin
                            sec_ones_d = dec_ones;
                            sec_tens_d = dec_tens;
                            mins_d     = dec_mins;
                            if (dec_zero) begin
                                tc_d    = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    // Prescaler is left untouched so a resume finishes the partial second.
                    if (!pause_i) begin
                        if (start_i) begin
                            state_d = ST_RUN;
                        end
`ifdef TIMER_ADD30_EN
                        else if (add30_i) begin
                            sec_ones_d = add_ones;
                            sec_tens_d = add_tens;
                            mins_d     = add_mins;
                        end
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q    <= ST_IDLE;
            sec_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            mins_q     <= '0;
            presc_q    <= '0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_ones_q <= sec_ones_d;
            sec_tens_q <= sec_tens_d;
            mins_q     <= mins_d;
            presc_q    <= presc_d;
            tc_q       <= tc_d;
        end
    end

    assign sec_ones_o = sec_ones_q;
    assign sec_tens_o = sec_tens_q;
    assign mins_o     = mins_q;
    assign running_o  = (state_q == ST_RUN);
    assign zero_o     = (mins_q == '0) && (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    assign tc_o       = tc_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer: three instances (2-digit fast, 2-digit /4 prescaler, 1-digit fast)
// share one stimulus bus; each scenario task checks the instance it targets.
// Inputs change 1 time unit after the rising edge and outputs are sampled at the same point.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       cancel = 1'b0;
    logic       add30 = 1'b0;

    logic [3:0] a_ones, a_tens, b_ones, b_tens, c_ones, c_tens, c_mins;
    logic [7:0] a_mins, b_mins;
    logic       a_run, a_zero, a_tc, b_run, b_zero, b_tc, c_run, c_zero, c_tc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(1)) u_a (
        .clk_i(clk), .clr_i(clr), .key_valid_i(key_valid), .key_digit_i(key_digit),
        .start_i(start), .pause_i(pause), .cancel_i(cancel), .add30_i(add30),
        .sec_ones_o(a_ones), .sec_tens_o(a_tens), .mins_o(a_mins),
        .running_o(a_run), .zero_o(a_zero), .tc_o(a_tc));

    bcd_countdown_timer #(.MIN_DIGITS(2), .TICK_DIV(4)) u_b (
        .clk_i(clk), .clr_i(clr), .key_valid_i(key_valid), .key_digit_i(key_digit),
        .start_i(start), .pause_i(pause), .cancel_i(cancel), .add30_i(add30),
        .sec_ones_o(b_ones), .sec_tens_o(b_tens), .mins_o(b_mins),
        .running_o(b_run), .zero_o(b_zero), .tc_o(b_tc));

    bcd_countdown_timer #(.MIN_DIGITS(1), .TICK_DIV(1)) u_c (
        .clk_i(clk), .clr_i(clr), .key_valid_i(key_valid), .key_digit_i(key_digit),
        .start_i(start), .pause_i(pause), .cancel_i(cancel), .add30_i(add30),
        .sec_ones_o(c_ones), .sec_tens_o(c_tens), .mins_o(c_mins),
        .running_o(c_run), .zero_o(c_zero), .tc_o(c_tc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        step();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        do_clr();
        n_cmp++;
        if ({a_mins, a_tens, a_ones} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_digits: got %h want 0000", {a_mins, a_tens, a_ones});
        end
        n_cmp++;
        if ({a_run, a_zero, a_tc} !== 3'b010) begin
            n_bad++; $display("FAIL reset_flags(run,zero,tc): got %b want 010", {a_run, a_zero, a_tc});
        end
        n_cmp++;
        if ({c_mins, c_tens, c_ones, c_run, c_zero, c_tc} !== 15'b000000000000_010) begin
            n_bad++; $display("FAIL reset_c: got %h/%b want 000/010", {c_mins, c_tens, c_ones}, {c_run, c_zero, c_tc});
        end
    endtask

    task automatic test_load_run();
        int tc_cnt;
        int tc_at;
        tc_cnt = 0;
        tc_at  = 0;
        do_clr();
        press(4'd1); press(4'd3); press(4'd0);
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_run} !== 17'h0130 << 1) begin
            n_bad++; $display("FAIL load_130: got %h run=%b want 0130 run=0", {a_mins, a_tens, a_ones}, a_run);
        end
        pulse_start();
        n_cmp++;
        if ({a_run, a_mins, a_tens, a_ones} !== {1'b1, 16'h0130}) begin
            n_bad++; $display("FAIL start_run: got run=%b %h want run=1 0130", a_run, {a_mins, a_tens, a_ones});
        end
        step();
        n_cmp++;
        if ({a_mins, a_tens, a_ones} !== 16'h0129) begin
            n_bad++; $display("FAIL first_dec: got %h want 0129", {a_mins, a_tens, a_ones});
        end
        for (int i = 2; i <= 100; i++) begin
            step();
            if (a_tc === 1'b1) begin
                tc_cnt++;
                tc_at = i;
            end
            if (i == 89) begin
                n_cmp++;
                if ({a_mins, a_tens, a_ones, a_run, a_tc} !== {16'h0001, 2'b10}) begin
                    n_bad++; $display("FAIL dec89: got %h run=%b tc=%b want 0001 run=1 tc=0", {a_mins, a_tens, a_ones}, a_run, a_tc);
                end
            end
            if (i == 90) begin
                n_cmp++;
                if ({a_tc, a_run, a_zero} !== 3'b101) begin
                    n_bad++; $display("FAIL dec90_flags(tc,run,zero): got %b want 101", {a_tc, a_run, a_zero});
                end
            end
        end
        n_cmp++;
        if (tc_cnt != 1 || tc_at != 90) begin
            n_bad++; $display("FAIL tc_once: got count=%0d at=%0d want count=1 at=90", tc_cnt, tc_at);
        end
        pulse_start();
        n_cmp++;
        if ({a_run, a_zero} !== 2'b01) begin
            n_bad++; $display("FAIL done_start_ignored: got run,zero=%b want 01", {a_run, a_zero});
        end
        press(4'd7);
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_run} !== {16'h0007, 1'b0}) begin
            n_bad++; $display("FAIL done_key: got %h run=%b want 0007 run=0", {a_mins, a_tens, a_ones}, a_run);
        end
        pulse_start();
        n_cmp++;
        if (a_run !== 1'b1) begin
            n_bad++; $display("FAIL idle_after_done_start: got run=%b want 1", a_run);
        end
    endtask

    task automatic test_prescaler();
        logic [3:0] exp_ones;
        do_clr();
        press(4'd2);
        pulse_start();
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_ones = (i < 4) ? 4'd2 : (i < 8) ? 4'd1 : 4'd0;
            n_cmp++;
            if ({b_mins, b_tens, b_ones, b_tc, b_run} !== {12'h000, exp_ones, (i == 8), (i < 8)}) begin
                n_bad++; $display("FAIL presc_step%0d: got %h tc=%b run=%b want 000%h tc=%b run=%b",
                                  i, {b_mins, b_tens, b_ones}, b_tc, b_run, exp_ones, (i == 8), (i < 8));
            end
        end
    endtask

    task automatic test_pause();
        do_clr();
        press(4'd4); press(4'd5);
        pulse_start();
        step(); step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        for (int i = 0; i < 10; i++) step();
        press(4'd9);
        n_cmp++;
        if ({b_mins, b_tens, b_ones, b_run} !== {16'h0045, 1'b0}) begin
            n_bad++; $display("FAIL pause_hold: got %h run=%b want 0045 run=0", {b_mins, b_tens, b_ones}, b_run);
        end
        pulse_start();
        step();
        n_cmp++;
        if ({b_mins, b_tens, b_ones, b_run} !== {16'h0045, 1'b1}) begin
            n_bad++; $display("FAIL resume_early: got %h run=%b want 0045 run=1", {b_mins, b_tens, b_ones}, b_run);
        end
        step();
        n_cmp++;
        if ({b_mins, b_tens, b_ones} !== 16'h0044) begin
            n_bad++; $display("FAIL resume_remaining: got %h want 0044", {b_mins, b_tens, b_ones});
        end
        for (int i = 0; i < 4; i++) step();
        n_cmp++;
        if ({b_mins, b_tens, b_ones} !== 16'h0043) begin
            n_bad++; $display("FAIL resume_full_period: got %h want 0043", {b_mins, b_tens, b_ones});
        end
    endtask

    task automatic test_borrow();
        do_clr();
        press(4'd1); press(4'd0); press(4'd0); press(4'd0);
        pulse_start();
        step();
        n_cmp++;
        if ({a_mins, a_tens, a_ones} !== 16'h0959) begin
            n_bad++; $display("FAIL borrow_1000: got %h want 0959", {a_mins, a_tens, a_ones});
        end
        pulse_cancel();
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_tc, a_run, a_zero} !== {16'h0000, 3'b001}) begin
            n_bad++; $display("FAIL cancel_run: got %h tc,run,zero=%b want 0000 001", {a_mins, a_tens, a_ones}, {a_tc, a_run, a_zero});
        end
        press(4'd1); press(4'd9); press(4'd0);
        pulse_start();
        step();
        n_cmp++;
        if ({a_mins, a_tens, a_ones} !== 16'h0189) begin
            n_bad++; $display("FAIL entered_190: got %h want 0189", {a_mins, a_tens, a_ones});
        end
        do_clr();
        press(4'd3); press(4'hA);
        n_cmp++;
        if ({a_mins, a_tens, a_ones} !== 16'h0003) begin
            n_bad++; $display("FAIL key_A_ignored: got %h want 0003", {a_mins, a_tens, a_ones});
        end
        do_clr();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        n_cmp++;
        if ({c_mins, c_tens, c_ones} !== 12'h345) begin
            n_bad++; $display("FAIL shift_drop: got %h want 345", {c_mins, c_tens, c_ones});
        end
    endtask

    task automatic test_cancel_clr();
        int tc_seen;
        tc_seen = 0;
        do_clr();
        press(4'd9);
        pulse_start();
        step();
        pulse_cancel();
        for (int i = 0; i < 6; i++) begin
            if (b_tc === 1'b1) tc_seen++;
            step();
        end
        n_cmp++;
        if ({b_mins, b_tens, b_ones, b_run, b_zero} !== {16'h0000, 2'b01} || tc_seen != 0) begin
            n_bad++; $display("FAIL cancel_slow: got %h run,zero=%b tc_seen=%0d want 0000 01 0", {b_mins, b_tens, b_ones}, {b_run, b_zero}, tc_seen);
        end
        press(4'd5); press(4'd0);
        pulse_start();
        step();
        do_clr();
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_run, a_zero, a_tc} !== {16'h0000, 3'b010}) begin
            n_bad++; $display("FAIL clr_midrun: got %h run,zero,tc=%b want 0000 010", {a_mins, a_tens, a_ones}, {a_run, a_zero, a_tc});
        end
    endtask

    task automatic test_start_pause();
        do_clr();
        press(4'd5);
        start = 1'b1;
        pause = 1'b1;
        step();
        start = 1'b0;
        pause = 1'b0;
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_run} !== {16'h0005, 1'b0}) begin
            n_bad++; $display("FAIL start_pause_idle: got %h run=%b want 0005 run=0", {a_mins, a_tens, a_ones}, a_run);
        end
        press(4'd1);
        n_cmp++;
        if ({a_mins, a_tens, a_ones, a_run} !== {16'h0051, 1'b0}) begin
            n_bad++; $display("FAIL still_idle_key: got %h run=%b want 0051 run=0", {a_mins, a_tens, a_ones}, a_run);
        end
    endtask

    task automatic pulse_add30();
        add30 = 1'b1;
        step();
        add30 = 1'b0;
    endtask

    task automatic test_add30();
        do_clr();
`ifdef TIMER_ADD30_EN
        pulse_add30();
        n_cmp++;
        if ({c_mins, c_tens, c_ones, c_run} !== {12'h030, 1'b1}) begin
            n_bad++; $display("FAIL add30_idle: got %h run=%b want 030 run=1", {c_mins, c_tens, c_ones}, c_run);
        end
        pulse_cancel();
        press(4'd9); press(4'd4); press(4'd5);
        pulse_add30();
        n_cmp++;
        if ({c_mins, c_tens, c_ones} !== 12'h959) begin
            n_bad++; $display("FAIL add30_saturate: got %h want 959", {c_mins, c_tens, c_ones});
        end
        pulse_cancel();
        press(4'd4); press(4'd0);
        pulse_add30();
        n_cmp++;
        if ({c_mins, c_tens, c_ones} !== 12'h110) begin
            n_bad++; $display("FAIL add30_carry: got %h want 110", {c_mins, c_tens, c_ones});
        end
`else
        pulse_add30();
        n_cmp++;
        if ({c_mins, c_tens, c_ones, c_run, c_zero} !== {12'h000, 2'b01}) begin
            n_bad++; $display("FAIL add30_off_zero: got %h run,zero=%b want 000 01", {c_mins, c_tens, c_ones}, {c_run, c_zero});
        end
        press(4'd7);
        pulse_add30();
        n_cmp++;
        if ({c_mins, c_tens, c_ones, c_run} !== {12'h007, 1'b0}) begin
            n_bad++; $display("FAIL add30_off_loaded: got %h run=%b want 007 run=0", {c_mins, c_tens, c_ones}, c_run);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_prescaler();
        test_pause();
        test_borrow();
        test_cancel_clr();
        test_start_pause();
        test_add30();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
